// File: rtl/prbs8_pkg.sv
// Shared PRBS-8 definitions: FSM states, register width and generator taps.
// Both the pattern generator and the checker take their feedback from here.
package prbs8_pkg;

    localparam int PRBS_W = 8;

    // Feedback taps d[4]^d[3]^d[2]^d[0] of the right-shifting Fibonacci LFSR
    localparam logic [PRBS_W-1:0] TAP_MASK = 8'b0001_1101;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    function automatic logic next_bit(input logic [PRBS_W-1:0] r);
        return ^(r & TAP_MASK);
    endfunction

endpackage

// File: rtl/prbs8_checker_if.sv
// Serial input and status bundle of the PRBS-8 checker.
interface prbs8_checker_if
    import prbs8_pkg::*;
#(
    parameter int ERR_W = 16
);
    logic              in_valid;
    logic              in_bit;
    logic              clr_err;
    logic              locked;
    logic              err_pulse;
    logic [ERR_W-1:0]  err_count;
    logic [1:0]        state;
    logic [PRBS_W-1:0] hist;

    modport master (
        output in_valid, in_bit, clr_err,
        input  locked, err_pulse, err_count, state, hist
    );

    modport slave (
        input  in_valid, in_bit, clr_err,
        output locked, err_pulse, err_count, state, hist
    );
endinterface

// File: rtl/lfsr8_step.sv
// Combinational feedback of the PRBS-8 LFSR: the bit the generator will emit
// once this register value has shifted out.
module lfsr8_step
    import prbs8_pkg::*;
(
    input  logic [PRBS_W-1:0] hist,
    output logic              pred
);
    assign pred = next_bit(hist);
endmodule

// File: rtl/prbs8_checker.sv
// Self-synchronising PRBS-8 checker: hunts, syncs on the live stream, then
// free-runs a local generator and counts every mismatched bit.
module prbs8_checker
    import prbs8_pkg::*;
#(
    parameter int LOCK_CNT = 16,
    parameter int LOSS_CNT = 4,
    parameter int ERR_W    = 16
)(
    input  logic            clk,
    input  logic            rst_n,
    prbs8_checker_if.slave  bus
);
    localparam int FILL_W  = 4;
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int MISS_W  = $clog2(LOSS_CNT + 1);

    state_t              state_reg, state_next;
    logic [PRBS_W-1:0]   hist_reg, hist_next;
    logic [FILL_W-1:0]   fill_reg, fill_next;
    logic [MATCH_W-1:0]  match_reg, match_next;
    logic [MISS_W-1:0]   miss_reg, miss_next;
    logic [ERR_W-1:0]    err_reg, err_next;
    logic                locked_reg, err_pulse_reg;
    logic                err_hit;
    logic                pred;

    lfsr8_step u_step (
        .hist (hist_reg),
        .pred (pred)
    );

    always_comb begin
        state_next = state_reg;
        hist_next  = hist_reg;
        fill_next  = fill_reg;
        match_next = match_reg;
        miss_next  = miss_reg;
        err_hit    = 1'b0;

        case (state_reg)
            HUNT: begin
                if (bus.in_valid) begin
                    hist_next = {bus.in_bit, hist_reg[PRBS_W-1:1]};
                    fill_next = fill_reg + FILL_W'(1);
                    if (fill_reg == FILL_W'(PRBS_W - 1)) begin
                        state_next = SYNC;
                        match_next = '0;
                    end
                end
            end
            SYNC: begin
                if (bus.in_valid) begin
                    hist_next = {bus.in_bit, hist_reg[PRBS_W-1:1]};
                    // An all-zero register predicts zeros forever; never trust it
                    if ((bus.in_bit == pred) && (hist_reg != '0))
                        match_next = match_reg + MATCH_W'(1);
                    else
                        match_next = '0;
                    if (match_next == MATCH_W'(LOCK_CNT)) begin
                        state_next = LOCKED;
                        miss_next  = '0;
                    end
                end
            end
            LOCKED: begin
                if (bus.in_valid) begin
                    // Shift our own prediction so one bad bit costs one error
                    hist_next = {pred, hist_reg[PRBS_W-1:1]};
                    if (bus.in_bit != pred) begin
                        err_hit   = 1'b1;
                        miss_next = miss_reg + MISS_W'(1);
                    end else begin
                        miss_next = '0;
                    end
                    if (miss_next == MISS_W'(LOSS_CNT)) begin
                        state_next = HUNT;
                        fill_next  = '0;
                    end
                end
            end
            default: begin
                state_next = HUNT;
                fill_next  = '0;
            end
        endcase
    end

    always_comb begin
        err_next = err_reg;
        if (bus.clr_err)
            err_next = err_hit ? ERR_W'(1) : '0;
        else if (err_hit && (err_reg != '1))
            err_next = err_reg + ERR_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= HUNT;
            hist_reg      <= '0;
            fill_reg      <= '0;
            match_reg     <= '0;
            miss_reg      <= '0;
            err_reg       <= '0;
            locked_reg    <= 1'b0;
            err_pulse_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            hist_reg      <= hist_next;
            fill_reg      <= fill_next;
            match_reg     <= match_next;
            miss_reg      <= miss_next;
            err_reg       <= err_next;
            locked_reg    <= (state_next == LOCKED);
            err_pulse_reg <= err_hit;
        end
    end

    assign bus.locked    = locked_reg;
    assign bus.err_pulse = err_pulse_reg;
    assign bus.err_count = err_reg;
    assign bus.state     = state_reg;
    assign bus.hist      = hist_reg;

endmodule
